// File: rtl/vga_capture_if.sv
// Video input bundle and capture results exchanged with vga_capture.
// The capture block is the slave; the video source and result consumer act as the master.
interface vga_capture_if;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned CSUM_W  = 32;

  logic               pix_en;
  logic               hsync;
  logic               vsync;
  logic               n_blanc;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               start;

  logic               busy;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [CSUM_W-1:0]  checksum;
  logic               frame_done;
  logic               h_err;
  logic               v_err;
  logic               timeout;

  modport master (
    output pix_en, hsync, vsync, n_blanc, r, g, b, start,
    input  busy, pix_valid, pix_x, pix_y, checksum, frame_done, h_err, v_err, timeout
  );

  modport slave (
    input  pix_en, hsync, vsync, n_blanc, r, g, b, start,
    output busy, pix_valid, pix_x, pix_y, checksum, frame_done, h_err, v_err, timeout
  );
endinterface

// File: rtl/vga_capture.sv
// Captures one full video frame on request: checksums visible pixels, checks line/frame
// geometry against the expected active size and aborts when vsync never arrives.
module vga_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned TIMEOUT  = 840000
) (
  input  logic          clk,
  input  logic          rst,
  vga_capture_if.slave  bus
);
  localparam int unsigned COORD_W = 10;
  localparam int unsigned CSUM_W  = 32;
  localparam int unsigned SUM_W   = 10;
  localparam int unsigned TCNT_W  = 20;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, CAPT, DONE} state_t;

  state_t              state, state_d;
  logic                prev_h, prev_v;
  logic [COORD_W-1:0]  x, x_d, y, y_d;
  logic [TCNT_W-1:0]   tcnt, tcnt_d;
  logic [CSUM_W-1:0]   csum, csum_d;
  logic                herr, herr_d, verr, verr_d, tout, tout_d;
  logic                busy_q, busy_d, pv_q, pv_d, fd_q, fd_d;
  logic [COORD_W-1:0]  px, px_d, py, py_d;

  logic                hfall, vfall;
  logic [COORD_W-1:0]  x_t, y_t;
  logic [TCNT_W-1:0]   tcnt_inc;
  logic [SUM_W-1:0]    pix_sum;

  // Edges are judged only between consecutive strobes.
  assign hfall = bus.pix_en & prev_h & ~bus.hsync;
  assign vfall = bus.pix_en & prev_v & ~bus.vsync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prev_h <= 1'b0;
      prev_v <= 1'b0;
      x      <= '0;
      y      <= '0;
      tcnt   <= '0;
      csum   <= '0;
      herr   <= 1'b0;
      verr   <= 1'b0;
      tout   <= 1'b0;
      busy_q <= 1'b0;
      pv_q   <= 1'b0;
      fd_q   <= 1'b0;
      px     <= '0;
      py     <= '0;
    end else begin
      state  <= state_d;
      if (bus.pix_en) begin
        prev_h <= bus.hsync;
        prev_v <= bus.vsync;
      end
      x      <= x_d;
      y      <= y_d;
      tcnt   <= tcnt_d;
      csum   <= csum_d;
      herr   <= herr_d;
      verr   <= verr_d;
      tout   <= tout_d;
      busy_q <= busy_d;
      pv_q   <= pv_d;
      fd_q   <= fd_d;
      px     <= px_d;
      py     <= py_d;
    end
  end

  always_comb begin
    state_d  = state;
    x_d      = x;
    y_d      = y;
    tcnt_d   = tcnt;
    csum_d   = csum;
    herr_d   = herr;
    verr_d   = verr;
    tout_d   = tout;
    pv_d     = 1'b0;
    fd_d     = 1'b0;
    px_d     = px;
    py_d     = py;
    x_t      = x;
    y_t      = y;
    tcnt_inc = tcnt + TCNT_W'(1);
    pix_sum  = SUM_W'(bus.r) + SUM_W'(bus.g) + SUM_W'(bus.b);

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = ARM;
          x_d     = '0;
          y_d     = '0;
          tcnt_d  = '0;
          csum_d  = '0;
          herr_d  = 1'b0;
          verr_d  = 1'b0;
          tout_d  = 1'b0;
          px_d    = '0;
          py_d    = '0;
        end
      end
      ARM: begin
        if (vfall) begin
          state_d = CAPT;
          tcnt_d  = '0;
        end else if (bus.pix_en) begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TCNT_W'(TIMEOUT)) begin
            tout_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      CAPT: begin
        if (bus.pix_en) begin
          if (bus.n_blanc) begin
            csum_d = csum + CSUM_W'(pix_sum);
            pv_d   = 1'b1;
            px_d   = x;
            py_d   = y;
            if (x != COORD_MAX) x_t = x + COORD_W'(1);
          end
          // Pixel of this strobe is already in x_t, so a same-strobe sync closes a line including it.
          if ((hfall || vfall) && x_t != '0) begin
            if (x_t != COORD_W'(H_ACTIVE)) herr_d = 1'b1;
            if (y_t != COORD_MAX) y_t = y_t + COORD_W'(1);
            x_t = '0;
          end
          x_d = x_t;
          y_d = y_t;
          if (vfall) begin
            if (y_t != COORD_W'(V_ACTIVE)) verr_d = 1'b1;
            tcnt_d  = '0;
            state_d = DONE;
            fd_d    = 1'b1;
          end else begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc == TCNT_W'(TIMEOUT)) begin
              tout_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.busy       = busy_q;
  assign bus.pix_valid  = pv_q;
  assign bus.pix_x      = px;
  assign bus.pix_y      = py;
  assign bus.checksum   = csum;
  assign bus.frame_done = fd_q;
  assign bus.h_err      = herr;
  assign bus.v_err      = verr;
  assign bus.timeout    = tout;
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 8x4 active geometry with a 300-strobe timeout.
module tb_vga_capture;
  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned TMO = 300;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_capture_if vif ();

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  typedef struct {
    int          lines;
    int          short_line;
    int          short_len;
    logic [7:0]  r, g, b;
    bit          mid_start;
    bit          merge;
    bit          open_last;
    logic [31:0] exp_sum;
    bit          exp_h;
    bit          exp_v;
    int          exp_x;
    int          exp_y;
    int          exp_pix;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (vif.pix_valid) pv_cnt++;
    if (vif.frame_done) fd_cnt++;
  endtask

  task automatic strobe(input logic h, input logic v, input logic nb,
                        input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    vif.pix_en  = 1'b1;
    vif.hsync   = h;
    vif.vsync   = v;
    vif.n_blanc = nb;
    vif.r = rr; vif.g = gg; vif.b = bb;
    tick();
  endtask

  task automatic line(input int n, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input bit merge, input bit close, input bit mid_start);
    for (int i = 0; i < n; i++) begin
      vif.start = mid_start && (i == 2);
      strobe((merge && close && i == n - 1) ? 1'b0 : 1'b1, 1'b1, 1'b1, rr, gg, bb);
      vif.start = 1'b0;
    end
    if (close) begin
      strobe(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      strobe(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic start_capture();
    vif.start = 1'b1;
    strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    vif.start = 1'b0;
  endtask

  task automatic enter_capt();
    strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    strobe(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    strobe(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic run_frame(input int idx, input vec_t t);
    int n;
    start_capture();
    check($sformatf("f%0d_start_busy", idx), 32'(vif.busy), 32'd1);
    check($sformatf("f%0d_start_sum", idx), vif.checksum, 32'd0);
    check($sformatf("f%0d_start_flags", idx), 32'({vif.h_err, vif.v_err, vif.timeout}), 32'd0);
    enter_capt();
    pv_cnt = 0;
    fd_cnt = 0;
    for (int l = 0; l < t.lines; l++) begin
      n = (l == t.short_line) ? t.short_len : int'(H);
      line(n, t.r, t.g, t.b, t.merge, !(t.open_last && l == t.lines - 1), t.mid_start && l == 1);
    end
    strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    strobe(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    check($sformatf("f%0d_done_pulse", idx), 32'(vif.frame_done), 32'd1);
    check($sformatf("f%0d_done_busy", idx), 32'(vif.busy), 32'd1);
    strobe(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    check($sformatf("f%0d_done_count", idx), 32'(fd_cnt), 32'd1);
    check($sformatf("f%0d_idle", idx), 32'(vif.busy), 32'd0);
    check($sformatf("f%0d_checksum", idx), vif.checksum, t.exp_sum);
    check($sformatf("f%0d_h_err", idx), 32'(vif.h_err), 32'(t.exp_h));
    check($sformatf("f%0d_v_err", idx), 32'(vif.v_err), 32'(t.exp_v));
    check($sformatf("f%0d_pixels", idx), 32'(pv_cnt), 32'(t.exp_pix));
    check($sformatf("f%0d_pix_x", idx), 32'(vif.pix_x), 32'(t.exp_x));
    check($sformatf("f%0d_pix_y", idx), 32'(vif.pix_y), 32'(t.exp_y));
    strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  vec_t vecs[7];

  initial begin
    //            lines short len   r    g    b   mid mrg open  sum    h v  x y  pix
    vecs[0] = '{4, -1, 0, 8'd255, 8'd0,   8'd0,   0, 0, 0, 32'd8160,  0, 0, 7, 3, 32};
    vecs[1] = '{4,  1, 7, 8'd255, 8'd0,   8'd0,   0, 0, 0, 32'd7905,  1, 0, 7, 3, 31};
    vecs[2] = '{3, -1, 0, 8'd1,   8'd2,   8'd3,   0, 0, 0, 32'd144,   0, 1, 7, 2, 24};
    vecs[3] = '{4, -1, 0, 8'd255, 8'd255, 8'd255, 1, 0, 0, 32'd24480, 0, 0, 7, 3, 32};
    vecs[4] = '{4,  0, 9, 8'd10,  8'd20,  8'd30,  0, 0, 0, 32'd1980,  1, 0, 7, 3, 33};
    vecs[5] = '{5, -1, 0, 8'd0,   8'd0,   8'd1,   0, 1, 0, 32'd40,    0, 1, 7, 4, 40};
    vecs[6] = '{4, -1, 0, 8'd100, 8'd100, 8'd100, 0, 1, 1, 32'd9600,  0, 0, 7, 3, 32};

    rst = 1'b1;
    vif.pix_en = 1'b0; vif.hsync = 1'b1; vif.vsync = 1'b1; vif.n_blanc = 1'b0;
    vif.r = 8'd0; vif.g = 8'd0; vif.b = 8'd0; vif.start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(vif.busy), 32'd0);
    check("rst_checksum", vif.checksum, 32'd0);
    check("rst_flags", 32'({vif.h_err, vif.v_err, vif.timeout, vif.frame_done, vif.pix_valid}), 32'd0);
    check("rst_coords", 32'({vif.pix_x, vif.pix_y}), 32'd0);

    // vsync never falls: abort after exactly TMO strobes, with idle gaps ignored
    fd_cnt = 0;
    start_capture();
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      if (i % 4 == 3) begin
        vif.pix_en = 1'b0;
        tick();
      end
      strobe(i[0], 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    end
    check("tmo_not_yet_busy", 32'(vif.busy), 32'd1);
    check("tmo_not_yet_flag", 32'(vif.timeout), 32'd0);
    strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    check("tmo_flag", 32'(vif.timeout), 32'd1);
    check("tmo_busy", 32'(vif.busy), 32'd0);
    check("tmo_no_done", 32'(fd_cnt), 32'd0);

    // short line raises h_err, a stalled strobe changes nothing, then async reset mid-frame
    start_capture();
    enter_capt();
    line(3, 8'd255, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    check("mid_h_err", 32'(vif.h_err), 32'd1);
    line(2, 8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("mid_sum", vif.checksum, 32'd1275);
    vif.pix_en = 1'b0; vif.n_blanc = 1'b1; vif.hsync = 1'b0; vif.vsync = 1'b0;
    tick();
    check("stall_sum", vif.checksum, 32'd1275);
    check("stall_pv", 32'(vif.pix_valid), 32'd0);
    check("stall_busy", 32'(vif.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(vif.busy), 32'd0);
    check("arst_checksum", vif.checksum, 32'd0);
    check("arst_flags", 32'({vif.h_err, vif.v_err, vif.timeout, vif.frame_done}), 32'd0);
    #2 rst = 1'b0;
    fd_cnt = 0;
    strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int l = 0; l < int'(V); l++) line(int'(H), 8'd1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    enter_capt();
    strobe(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    check("arst_no_done", 32'(fd_cnt), 32'd0);
    check("arst_idle", 32'(vif.busy), 32'd0);
    check("arst_sum_idle", vif.checksum, 32'd0);
    strobe(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);

    for (int k = 0; k < 7; k++) run_frame(k, vecs[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
